// File: rtl/score_display_if.sv
// Bundle of the score input and display/status outputs of the score display driver.
interface score_display_if;
  logic signed [31:0] score_in;
  logic        [6:0]  seg;
  logic        [3:0]  an;
  logic        [15:0] bcd_out;
  logic               busy;
  logic               overflow;

  // Score source: drives the score word, observes the display and status.
  modport master (
    output score_in,
    input  seg, an, bcd_out, busy, overflow
  );

  // Display driver: consumes the score word, produces the display and status.
  modport slave (
    input  score_in,
    output seg, an, bcd_out, busy, overflow
  );
endinterface

// File: rtl/score_display_driver.sv
// Converts a signed score to four BCD digits (double dabble, clamped to 0..9999)
// and time-multiplexes them onto a 4-digit active-low 7-segment display.
module score_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic           clock,
  input  logic           reset,
  score_display_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] last_score_q, last_score_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic        [15:0] bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic        [13:0] work_q, work_d;
  logic        [15:0] scratch_q, scratch_d;
  logic [CNT_W-1:0]   scan_q, scan_d;
  logic        [1:0]  idx_q, idx_d;
  logic               busy_o;
  logic        [3:0]  digit;
  logic               blank;

  // Saturate a signed score into 0..9999; MSB of the result is the overflow flag.
  function automatic logic [14:0] clamp_score(input logic signed [31:0] s);
    if (s < 0)
      return 15'd0;
    else if (s > 32'sd9999)
      return {1'b1, 14'd9999};
    else
      return {1'b0, s[13:0]};
  endfunction

  // One double-dabble step: correct nibbles >=5, then shift {scratch, work} left.
  function automatic logic [29:0] dabble_step(input logic [15:0] s, input logic [13:0] w);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    end
    return {adj, w} << 1;
  endfunction

  // Active-low {g,f,e,d,c,b,a} code; non-decimal nibbles are dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Control and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_score_q <= '0;
      cnt_q        <= '0;
      ovf_flag_q   <= 1'b0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      scan_q       <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_score_q <= last_score_d;
      cnt_q        <= cnt_d;
      ovf_flag_q   <= ovf_flag_d;
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
    end
  end

  // Conversion working registers; always reloaded on capture, so no reset needed.
  always_ff @(posedge clock) begin
    work_q    <= work_d;
    scratch_q <= scratch_d;
  end

  // Next-state: start on a new score, run 14 shifts, spend one edge publishing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.score_in != last_score_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state_q != IDLE);
  end

  // Conversion datapath: capture/clamp, shift-add steps, publish result.
  always_comb begin
    last_score_d = last_score_q;
    ovf_flag_d   = ovf_flag_q;
    work_d       = work_q;
    scratch_d    = scratch_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.score_in != last_score_q) begin
          last_score_d         = bus.score_in;
          {ovf_flag_d, work_d} = clamp_score(bus.score_in);
          scratch_d            = '0;
          cnt_d                = 4'd14;
        end
      end
      SHIFT: begin
        {scratch_d, work_d} = dabble_step(scratch_q, work_q);
        cnt_d               = cnt_q - 4'd1;
      end
      DONE: begin
        bcd_d = scratch_q;
        ovf_d = ovf_flag_q;
      end
      default: ;
    endcase
  end

  // Digit scan: hold each digit SCAN_DIV clocks, then advance the index.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Segment/anode drive with leading-zero blanking; digit 0 always shows.
  always_comb begin
    digit = bcd_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: begin digit = bcd_q[3:0];   blank = 1'b0;                  end
      2'd1: begin digit = bcd_q[7:4];   blank = (bcd_q[15:4]  == '0);  end
      2'd2: begin digit = bcd_q[11:8];  blank = (bcd_q[15:8]  == '0);  end
      2'd3: begin digit = bcd_q[15:12]; blank = (bcd_q[15:12] == '0);  end
      default: ;
    endcase
    bus.seg = blank ? 7'b1111111 : seg_code(digit);
    bus.an  = ~(4'b0001 << idx_q);
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_o;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with a fast scan (SCAN_DIV=4).
module tb_score_display_driver;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  score_display_if bus();

  score_display_driver #(.SCAN_DIV(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Align to the first edge of digit 0, then walk all four digits for 4 clocks each.
  task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [3:0] prev;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    bit found;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = bus.an;
      tick();
      if (bus.an == 4'b1110 && prev == 4'b0111) found = 1'b1;
    end
    check({tag, "_sync"}, {31'd0, found}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s_an_d%0d_c%0d", tag, d, c), {28'd0, bus.an}, {28'd0, exp_an[d]});
        check($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {25'd0, bus.seg}, {25'd0, exp_seg[d]});
        tick();
      end
    end
  endtask

  // Apply a score just after an edge and wait edges k..k+15.
  task automatic convert(input logic [31:0] score);
    bus.score_in = score;
    tick(16);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.score_in = 32'd0;
    #3;
    check("rst_an", {28'd0, bus.an}, 32'h0000000E);
    check("rst_seg", {25'd0, bus.seg}, 32'h00000040);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_bcd", {16'd0, bus.bcd_out}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("zero_no_conv", {31'd0, bus.busy}, 32'd0);

    // 1234: busy through edges k..k+14, result after k+15.
    bus.score_in = 32'd1234;
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("conv_busy_%0d", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("conv_bcd_hold_%0d", i), {16'd0, bus.bcd_out}, 32'd0);
      tick();
    end
    check("b1234_bcd", {16'd0, bus.bcd_out}, 32'h00001234);
    check("b1234_busy", {31'd0, bus.busy}, 32'd0);
    check("b1234_ovf", {31'd0, bus.overflow}, 32'd0);
    check_scan("s1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    convert(32'd12345);
    check("b12345_bcd", {16'd0, bus.bcd_out}, 32'h00009999);
    check("b12345_ovf", {31'd0, bus.overflow}, 32'd1);

    convert(32'd42);
    check("b42_bcd", {16'd0, bus.bcd_out}, 32'h00000042);
    check("b42_ovf", {31'd0, bus.overflow}, 32'd0);
    check_scan("s42", 7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111);

    convert(32'hFFFFFFFB);
    check("bneg_bcd", {16'd0, bus.bcd_out}, 32'h00000000);
    check("bneg_ovf", {31'd0, bus.overflow}, 32'd0);
    check_scan("sneg", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

    convert(32'd7);
    check("b7_bcd", {16'd0, bus.bcd_out}, 32'h00000007);
    check_scan("s7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);

    // Score change while busy is deferred to the next IDLE edge.
    bus.score_in = 32'd1234;
    tick(3);
    bus.score_in = 32'd56;
    tick(13);
    check("defer_first_bcd", {16'd0, bus.bcd_out}, 32'h00001234);
    check("defer_first_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("defer_restart_busy", {31'd0, bus.busy}, 32'd1);
    tick(15);
    check("defer_second_bcd", {16'd0, bus.bcd_out}, 32'h00000056);
    check("defer_second_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-SHIFT aborts asynchronously; conversion restarts after release.
    bus.score_in = 32'd999;
    tick(6);
    check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_bcd", {16'd0, bus.bcd_out}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_an", {28'd0, bus.an}, 32'h0000000E);
    check("abort_seg", {25'd0, bus.seg}, 32'h00000040);
    #1;
    rst = 1'b0;
    tick();
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    tick(15);
    check("restart_bcd", {16'd0, bus.bcd_out}, 32'h00000999);
    check("restart_done_busy", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
SCORE_DISPLAY_DRIVER -- requirements
Module: score_display_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: clock cycles each digit stays enabled.
REQ-002 SHALL have port clock  input  1  master clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port score_in  input  32  signed score word from the processor score output.
REQ-005 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-006 SHALL have port an  output  4  active-low one-hot digit enable; an[0] is the least-significant digit.
REQ-007 SHALL have port bcd_out  output  16  four packed BCD digits; [3:0] is the ones digit.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port overflow  output  1  high when the last converted score exceeded 9999.

Function
REQ-010 SHALL implement the states IDLE, SHIFT and DONE.
REQ-011 In IDLE, SHALL compare score_in against register last_score on every edge.
REQ-012 On inequality in IDLE, SHALL capture score_in into last_score and load the clamped value into a 14-bit work register.
REQ-013 On that same edge, SHALL clear the 16-bit BCD scratch register, load shift count 14, and enter SHIFT.
REQ-014 Clamp rule: bit31=1 -> 0 with overflow flag 0; unsigned value >9999 -> 9999 with overflow flag 1; otherwise the value with overflow flag 0.
REQ-015 In SHIFT, each edge SHALL add 3 to every scratch nibble >=5, then shift {scratch, work} left by one bit, then decrement the count.
REQ-016 SHALL leave SHIFT after exactly 14 edges and enter DONE.
REQ-017 In DONE, SHALL copy scratch to bcd_out and the overflow flag to overflow on one edge, then return to IDLE.
REQ-018 busy SHALL be 1 exactly in SHIFT and DONE.
REQ-019 Latency: capture at edge k -> bcd_out and overflow updated at edge k+15; busy is 0 after edge k+15.
REQ-020 SHALL ignore score_in changes while busy; IDLE re-compares afterwards, so the latest value is always converted eventually.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap.
REQ-022 On each wrap, the 2-bit digit index SHALL increment modulo 4.
REQ-023 an SHALL drive low only the bit selected by the digit index.
REQ-024 seg SHALL show the selected bcd_out nibble in standard active-low 7-segment code.
REQ-025 Nibble values 10..15 SHALL drive seg to 7'b1111111.
REQ-026 Leading-zero blanking: digit i (i=3..1) SHALL drive seg to 7'b1111111 when it and all higher digits are zero.
REQ-027 Digit 0 SHALL never be blanked.
REQ-028 seg and an SHALL update combinationally from bcd_out and the digit index; a bcd_out change appears on the currently scanned digit immediately.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, last_score=0, bcd_out=0, overflow=0, busy=0, scan counter=0 and digit index=0, independent of clock.
REQ-030 During reset, SHALL output an=4'b1110 and seg=7'b1000000.
REQ-031 Reset asserted mid-conversion SHALL abort it; no partial result SHALL reach bcd_out.
REQ-032 score_in=0 after reset SHALL start no conversion.

Verification
REQ-033 SCAN_DIV=4; score_in=1234 applied at edge k -> busy=1 during edges k+1..k+15; bcd_out=16'h1234 after edge k+15; an cycles 1110,1101,1011,0111 for 4 clocks each; seg on an=1110 is 7'b0011001.
REQ-034 score_in=12345 -> bcd_out=16'h9999, overflow=1.
REQ-034a Next, score_in=42 -> bcd_out=16'h0042, overflow=0; digits 3 and 2 blank.
REQ-035 score_in=32'hFFFFFFFB -> bcd_out=16'h0000, overflow=0; only digit 0 lit with seg=7'b1000000.
REQ-036 score_in=7 -> on an=1110, seg=7'b1111000; digits 3..1 read 7'b1111111.
REQ-037 score_in=1234, then score_in=56 three edges later -> bcd_out=16'h1234 first; a second conversion starts on the first IDLE edge and produces 16'h0056 fifteen edges later.
REQ-038 reset pulsed during SHIFT (scratch nonzero) -> bcd_out=0 and busy=0 with no clock edge; after release, score_in unchanged and nonzero -> full conversion restarts.
